instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage sitting directly upstream of the combinational-read `fast_memory`. It owns the program counter, drives the memory's address port, and captures 32-bit instructions into a 2-entry queue. The decoder drains the queue over a valid/ready handshake. Data accesses from the execute stage are multiplexed onto the same single memory port with priority over fetch, and branch redirects flush the queue.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset; must be word aligned.
- `MEM_BYTES`, default 1024: size of the attached memory; fetches at or beyond `MEM_BYTES-3` are faulted.
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_address`  out  32  address to memory.
- `mem_write_en`  out  1  memory write enable; only ever set by data port.
- `mem_write_data`  out  32  memory write data.
- `mem_read_data`  in  32  combinational memory read data.
- `dmem_req`  in  1  execute-stage data access this cycle; always granted.
- `dmem_we`  in  1  data access is a store.
- `dmem_addr`  in  32  data address.
- `dmem_wdata`  in  32  store data.
- `dmem_rdata`  out  32  load data, `mem_read_data` passed through in the same cycle.
- `redirect_valid`  in  1  branch/PC write taken.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored.
- `instr_valid`  out  1  queue head valid.
- `instr_ready`  in  1  decoder accepts head.
- `instr_data`  out  32  head instruction.
- `instr_pc`  out  32  head address.
- `instr_fault`  out  1  head came from an out-of-range fetch.
- `perf_stall_count`, `perf_flush_count`  out  32  each; see Configuration.

## Operation
- State: `fetch_pc` (32b, word aligned) and a 2-entry FIFO of {pc, data, fault} with a 2-bit count.
- Port mux:
  - `dmem_req`=1: `mem_address=dmem_addr` and `mem_write_en=dmem_we`; no fetch that cycle. This is a stall.
  - Otherwise: `mem_address=fetch_pc` and `mem_write_en=0`.
- `mem_write_data=dmem_wdata` at all times.
- Push condition: no `dmem_req`, no `redirect_valid`, not `reset`, and (count<2 or pop this cycle).
  - On push, enqueue {fetch_pc, data, fault}; `fetch_pc += 4`, wrapping modulo 2^32.
- Fault:
  - If `fetch_pc >= MEM_BYTES-3`, the entry is pushed with fault=1 and data=32'hE1A00000 (NOP). The PC still advances.
  - Never forward x.
- Pop: `instr_valid && instr_ready`. Outputs always show the head entry; when empty, `instr_data`/`instr_pc` hold their last values.
- Full with pop and push in the same cycle: legal; count stays 2 and order is preserved.
- Redirect: on the next edge the queue is cleared (count=0) and `fetch_pc <= {redirect_pc[31:2],2'b00}`.
  - Any same-cycle pop or push is discarded.
  - A same-cycle `dmem_req` still completes its memory access.
- Reset priority: reset > redirect > push/pop.

## Timing
- Reset values: `fetch_pc=RESET_VECTOR`, count=0, `instr_valid=0`, `instr_fault=0`, `instr_data=0`, `instr_pc=0`, perf counters=0.
- During reset: `mem_write_en=0` unless `dmem_req`; `mem_address=fetch_pc`.
- Fetch latency: 1 cycle. An address driven in cycle T appears at the head with `instr_valid=1` in cycle T+1 if the queue was empty.
- First instruction: valid in the second cycle after `reset` deasserts.
- Redirect: asserted in cycle T, target fetched in T+1, target instruction valid in T+2. `instr_valid=0` in T+1.
- Throughput: 1 instruction/cycle with `instr_ready` held high and no data accesses.
- `dmem_rdata` is combinational; the execute stage samples it in the same cycle.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_stall_count` increments on each non-reset cycle with `dmem_req`=1.
  - `perf_flush_count` increments on each `redirect_valid` cycle.
  - Both are 32-bit, wrap, and clear on reset.
- Not defined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Package `fetch_pkg` holds:
  - `NOP_INSTR` = 32'hE1A00000;
  - the default reset vector;
  - the queue entry typedef {pc[31:0], data[31:0], fault}.
- Sub-module `fetch_queue`: a 2-deep synchronous FIFO with push, pop and flush ports, count output, and simultaneous push/pop when full.
- Top level holds the PC, port mux, fault check and perf counters.

## Test plan
- Reset, boot ROM loaded, `instr_ready`=1: head sequence pc 0/4/8 with data 32'hE3A00000, 32'hEB000001, 32'hE1A00000. First valid appears 2 cycles after reset release.
- `instr_ready`=0 for 5 cycles: count saturates at 2 (pc 0, 4) and `fetch_pc` holds 8. After release, 0/4/8 follow in order with no duplicate or loss.
- `dmem_req` store of 32'hDEADBEEF to 0x100 mid-stream:
  - `mem_write_en`=1 and `mem_address`=0x100 that cycle;
  - fetch resumes at the same pc;
  - `perf_stall_count`=1 with `FETCH_PERF_EN`;
  - a later fetch of 0x100 returns 32'hDEADBEEF.
- Redirect to 0x10 while full and popping: no stale entries. Next valid head is pc 0x10, data 32'hE2800001, two cycles later.
- `MEM_BYTES`=1024:
  - redirect to 0x3FC: valid entry with fault=0;
  - the following fetch at 0x400: `instr_fault`=1, data 32'hE1A00000.
- `reset` asserted with a full queue: `instr_valid`=0 the next cycle, and fetching restarts at `RESET_VECTOR`.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// fetch_pkg -- shared constants and the queue entry type for the fetch stage.
// Rev 1.0
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'hE1A0_0000;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// fetch_queue -- 2-deep instruction FIFO with flush and full-throughput push/pop.
// Rev 1.0
module fetch_queue
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_data,
  input  logic        push_fault,
  output logic [31:0] head_pc,
  output logic [31:0] head_data,
  output logic        head_fault,
  output logic [1:0]  count
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  fetch_entry_t in_entry;
  logic [1:0]   cnt;

  assign in_entry = '{pc: push_pc, data: push_data, fault: push_fault};

  // slot0 is always the head; it is left untouched when the queue drains so
  // the decoder-facing pc/data hold their last values while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            slot0 <= in_entry;
            cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0 <= in_entry;
          end else if (push) begin
            slot1 <= in_entry;
            cnt   <= 2'd2;
          end else if (pop) begin
            cnt <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            slot0 <= slot1;
            if (push) begin
              slot1 <= in_entry;
            end else begin
              cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign head_pc    = slot0.pc;
  assign head_data  = slot0.data;
  assign head_fault = slot0.fault;
  assign count      = cnt;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// instruction_fetch -- PC, shared memory port mux and fetch queue; optional
// perf counters under FETCH_PERF_EN. Rev 1.0
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          MEM_BYTES    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  output logic [31:0] perf_stall_count,
  output logic [31:0] perf_flush_count
);

  localparam logic [31:0] FAULT_LIMIT = 32'(MEM_BYTES - 3);

  logic [31:0] fetch_pc;
  logic [1:0]  q_count;
  logic        q_head_fault;
  logic        pop;
  logic        push;
  logic        fetch_fault;
  logic [31:0] fetch_data;
  logic        unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  // Data accesses always win the single memory port.
  assign mem_address    = dmem_req ? dmem_addr : fetch_pc;
  assign mem_write_en   = dmem_req & dmem_we;
  assign mem_write_data = dmem_wdata;
  assign dmem_rdata     = mem_read_data;

  assign pop         = instr_valid & instr_ready;
  assign push        = ~dmem_req & ~redirect_valid & ~reset & ((q_count != 2'd2) | pop);
  assign fetch_fault = (fetch_pc >= FAULT_LIMIT);
  assign fetch_data  = fetch_fault ? NOP_INSTR : mem_read_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_VECTOR;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_pc   (fetch_pc),
    .push_data (fetch_data),
    .push_fault(fetch_fault),
    .head_pc   (instr_pc),
    .head_data (instr_data),
    .head_fault(q_head_fault),
    .count     (q_count)
  );

  assign instr_valid = (q_count != 2'd0);
  assign instr_fault = q_head_fault & instr_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (dmem_req) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (redirect_valid) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign perf_stall_count = stall_cnt;
  assign perf_flush_count = flush_cnt;
`else
  assign perf_stall_count = 32'd0;
  assign perf_flush_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// tb_instruction_fetch -- directed scenarios plus randomized traffic checked by
// a sequential-stream scoreboard against a behavioural memory model.
module tb_instruction_fetch;

  localparam logic [31:0] RV        = 32'h0000_0000;
  localparam int          MEM_BYTES = 1024;
  localparam logic [31:0] NOP       = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic [31:0] perf_stall_count;
  logic [31:0] perf_flush_count;

  instruction_fetch #(.RESET_VECTOR(RV), .MEM_BYTES(MEM_BYTES)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_write_en    (mem_write_en),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .instr_fault     (instr_fault),
    .perf_stall_count(perf_stall_count),
    .perf_flush_count(perf_flush_count)
  );

  always #5 clk = ~clk;

  // Behavioural fast_memory: combinational read, write on the clock edge.
  logic [31:0] mem [0:255];
  assign mem_read_data = (mem_address < 32'(MEM_BYTES)) ? mem[mem_address[9:2]] : 32'h0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'hE3A0_0000;
    mem[1] = 32'hEB00_0001;
    mem[2] = 32'hE1A0_0000;
    mem[4] = 32'hE280_0001;
    forever begin
      @(posedge clk);
      if (mem_write_en && mem_address < 32'(MEM_BYTES)) mem[mem_address[9:2]] <= mem_write_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the decoder must see a sequential word stream starting at
  // the reset vector or the latest redirect target.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] model_pc = RV;
  logic [31:0] last_pc  = RV;
  int          stall_n  = 0;
  int          flush_n  = 0;
  int          n_acc    = 0;

  function automatic exp_t make_exp(input logic [31:0] pc);
    exp_t r;
    r.pc    = pc;
    r.fault = (pc >= 32'(MEM_BYTES - 3));
    r.data  = r.fault ? NOP : mem[pc[9:2]];
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_pc = RV;
      last_pc  = RV;
      stall_n  = 0;
      flush_n  = 0;
    end else begin
      if (instr_valid && instr_ready && !redirect_valid) begin
        e = exp_q.pop_front();
        check("sb_pc", instr_pc, e.pc);
        check("sb_data", instr_data, e.data);
        check("sb_fault", {31'd0, instr_fault}, {31'd0, e.fault});
        last_pc = e.pc;
        n_acc++;
      end
      if (dmem_req) begin
        stall_n++;
        check("dmem_addr_mux", mem_address, dmem_addr);
        check("dmem_we_mux", {31'd0, mem_write_en}, {31'd0, dmem_we});
        if (!dmem_we && dmem_addr < 32'(MEM_BYTES)) check("dmem_rdata", dmem_rdata, mem[dmem_addr[9:2]]);
      end else begin
        check("fetch_no_write", {31'd0, mem_write_en}, 32'd0);
      end
      if (redirect_valid) begin
        flush_n++;
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
        last_pc  = model_pc;
      end
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(make_exp(model_pc));
      model_pc = model_pc + 32'd4;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [31:0] pre_addr;
  logic [31:0] w3fc;
  int          acc_start;

  initial begin
    reset = 1'b1; instr_ready = 1'b1;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    repeat (3) cyc();
    mid();
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_data", instr_data, 32'd0);
    check("rst_fault", {31'd0, instr_fault}, 32'd0);
    check("rst_perf_stall", perf_stall_count, 32'd0);
    check("rst_perf_flush", perf_flush_count, 32'd0);
    check("rst_addr", mem_address, RV);

    // Boot stream: first valid two cycles after release, then 1/cycle
    cyc(); reset = 1'b0;
    mid(); check("boot_c0_valid", {31'd0, instr_valid}, 32'd0);
    check("boot_c0_addr", mem_address, RV);
    cyc(); mid(); check("boot_c1_valid", {31'd0, instr_valid}, 32'd1);
    check("boot_pc0", instr_pc, 32'h0); check("boot_d0", instr_data, 32'hE3A0_0000);
    cyc(); mid(); check("boot_pc4", instr_pc, 32'h4); check("boot_d4", instr_data, 32'hEB00_0001);
    cyc(); mid(); check("boot_pc8", instr_pc, 32'h8); check("boot_d8", instr_data, NOP);
    check("boot_f8", {31'd0, instr_fault}, 32'd0);

    // Backpressure: queue saturates at pc 0,4 and fetch_pc holds at 8
    cyc(); reset = 1'b1; instr_ready = 1'b0;
    cyc(); reset = 1'b0;
    repeat (4) cyc();
    mid(); check("bp_valid", {31'd0, instr_valid}, 32'd1);
    check("bp_head", instr_pc, 32'h0); check("bp_fetch_pc", mem_address, 32'h8);
    cyc(); instr_ready = 1'b1;
    mid(); check("bp_rel0", instr_pc, 32'h0);
    cyc(); mid(); check("bp_rel4", instr_pc, 32'h4);
    cyc(); mid(); check("bp_rel8", instr_pc, 32'h8);

    // Store mid-stream stalls fetch for one cycle
    cyc(); pre_addr = mem_address;
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h100; dmem_wdata = 32'hDEAD_BEEF;
    mid(); check("st_we", {31'd0, mem_write_en}, 32'd1);
    check("st_addr", mem_address, 32'h100); check("st_wdata", mem_write_data, 32'hDEAD_BEEF);
    cyc(); dmem_req = 1'b0; dmem_we = 1'b0;
    mid(); check("st_resume_pc", mem_address, pre_addr);
`ifdef FETCH_PERF_EN
    check("st_perf_stall", perf_stall_count, 32'd1);
`else
    check("st_perf_stall", perf_stall_count, 32'd0);
`endif
    cyc(); dmem_req = 1'b1; dmem_addr = 32'h100;
    mid(); check("ld_rdata", dmem_rdata, 32'hDEAD_BEEF);
    cyc(); dmem_req = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc(); redirect_valid = 1'b0;
    mid(); check("rd100_gap", {31'd0, instr_valid}, 32'd0);
    cyc(); mid(); check("rd100_valid", {31'd0, instr_valid}, 32'd1);
    check("rd100_pc", instr_pc, 32'h100); check("rd100_data", instr_data, 32'hDEAD_BEEF);

    // Redirect while full and popping; low target bits ignored
    cyc(); instr_ready = 1'b0;
    repeat (2) cyc();
    cyc(); instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h13;
    mid(); check("rdfull_valid", {31'd0, instr_valid}, 32'd1);
    cyc(); redirect_valid = 1'b0;
    mid(); check("rd10_gap", {31'd0, instr_valid}, 32'd0);
    cyc(); mid(); check("rd10_valid", {31'd0, instr_valid}, 32'd1);
    check("rd10_pc", instr_pc, 32'h10); check("rd10_data", instr_data, 32'hE280_0001);

    // Memory-end boundary
    w3fc = mem[255];
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    cyc(); redirect_valid = 1'b0;
    cyc(); mid(); check("end_valid", {31'd0, instr_valid}, 32'd1);
    check("end_pc", instr_pc, 32'h3FC); check("end_fault", {31'd0, instr_fault}, 32'd0);
    check("end_data", instr_data, w3fc);
    cyc(); mid(); check("oob_pc", instr_pc, 32'h400);
    check("oob_fault", {31'd0, instr_fault}, 32'd1); check("oob_data", instr_data, NOP);

    // Reset with a full queue
    cyc(); instr_ready = 1'b0;
    repeat (2) cyc();
    cyc(); reset = 1'b1;
    mid(); check("rstfull_pre", {31'd0, instr_valid}, 32'd1);
    cyc(); reset = 1'b0; instr_ready = 1'b1;
    mid(); check("rstfull_valid", {31'd0, instr_valid}, 32'd0);
    check("rstfull_addr", mem_address, RV);
    cyc(); mid(); check("rstfull_restart", instr_pc, RV);
    check("rstfull_data", instr_data, 32'hE3A0_0000);

    // Randomized traffic; stream kept below 0x200, stores kept at 0x300+
    acc_start = n_acc;
    for (int i = 0; i < 600; i++) begin
      cyc();
      instr_ready    = ($urandom_range(0, 3) != 0);
      dmem_req       = ($urandom_range(0, 5) == 0);
      dmem_we        = 1'($urandom_range(0, 1));
      dmem_addr      = 32'h300 + 32'(4 * $urandom_range(0, 62));
      dmem_wdata     = $urandom;
      redirect_valid = ($urandom_range(0, 11) == 0) || (last_pc >= 32'h180);
      redirect_pc    = 32'($urandom_range(0, 32'h1FF));
    end
    cyc();
    instr_ready = 1'b1; dmem_req = 1'b0; dmem_we = 1'b0; redirect_valid = 1'b0;
    repeat (2) cyc();
    mid();
    check("rand_progress", {31'd0, (n_acc - acc_start) > 100}, 32'd1);
`ifdef FETCH_PERF_EN
    check("perf_stall", perf_stall_count, 32'(stall_n));
    check("perf_flush", perf_flush_count, 32'(flush_n));
`else
    check("perf_stall", perf_stall_count, 32'd0);
    check("perf_flush", perf_flush_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
